sio_sd_bridge: RTL and testbench

//   Parametrised successor to the inline ZPU<->hps_io SD glue in the Atari800 top level.

---
 rtl/sio_sd_bridge_if.sv | 36 +++
 rtl/sio_sd_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_sio_sd_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sio_sd_bridge_if.sv
// rtl/sio_sd_bridge_if.sv - hps_io block-device port bundle for sio_sd_bridge
// Purpose : groups the hps_io block-device and mount signals.
// Modports: master - bridge side (drives sd_lba/sd_rd/sd_wr/sd_buff_din)
//           slave  - hps_io side (drives ack, buffer bus and mount info)
// Signals : sd_lba[31:0], sd_rd/sd_wr[NDRV], sd_ack, sd_buff_addr[BLK_AW],
//           sd_buff_dout[8], sd_buff_wr, sd_buff_din[8], img_mounted[NDRV],
//           img_readonly, img_size[64], ioctl_index[8]
interface sio_sd_bridge_if #(
  parameter int NDRV   = 3,
  parameter int BLK_AW = 9
) ();
  logic [31:0]       sd_lba;
  logic [NDRV-1:0]   sd_rd;
  logic [NDRV-1:0]   sd_wr;
  logic              sd_ack;
  logic [BLK_AW-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [NDRV-1:0]   img_mounted;
  logic              img_readonly;
  logic [63:0]       img_size;
  logic [7:0]        ioctl_index;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  img_mounted, img_readonly, img_size, ioctl_index
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output img_mounted, img_readonly, img_size, ioctl_index
  );
endinterface

// File: rtl/sio_sd_bridge.sv
// rtl/sio_sd_bridge.sv - ZPU SIO firmware to hps_io block-device bridge
// Purpose : sector buffer, LBA register, per-slot block requests with
//           timeout, and a queue of pending mount reports.
// Ports   : clk_sys, areset (sync, active-high)
//           zpu_ctl[6] {drv[2:0], blk_wr, blk_rd, lba_sel}, zpu_wdata[32],
//           zpu_data_wr, zpu_data_rd, zpu_io_wr  (ZPU strobes in)
//           zpu_status[8] {readonly, filetype[1:0], fileno[2:0], mnt_toggle, io_done},
//           zpu_err, zpu_rdata[32]               (ZPU readback out)
//           sd (sio_sd_bridge_if.master)         (hps_io block-device port)
module sio_sd_bridge #(
  parameter int              NDRV     = 3,
  parameter int              BLK_AW   = 9,
  parameter logic [23:0]     TIMEOUT  = 24'd8000000,
  parameter logic [15:0]     MNT_HOLD = 16'd4096,
  parameter logic [NDRV-1:0] RO_MASK  = '0
) (
  input  logic                   clk_sys,
  input  logic                   areset,
  input  logic [5:0]             zpu_ctl,
  input  logic [31:0]            zpu_wdata,
  input  logic                   zpu_data_wr,
  input  logic                   zpu_data_rd,
  input  logic                   zpu_io_wr,
  output logic [7:0]             zpu_status,
  output logic                   zpu_err,
  output logic [31:0]            zpu_rdata,
  sio_sd_bridge_if.master        sd
);

  localparam int DEPTH = 1 << BLK_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  // ZPU strobe sampling: data strobes get two sync flops plus one edge flop
  logic [2:0] wr_sync, rd_sync;
  logic [5:0] ctl_s;
  logic [1:0] cmd_q;
  logic       wr_rise, rd_fall, cmd_rd_rise, cmd_wr_rise, lba_sel;
  logic [2:0] drv;

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      wr_sync <= '0;
      rd_sync <= '0;
      ctl_s   <= '0;
      cmd_q   <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], zpu_data_wr};
      rd_sync <= {rd_sync[1:0], zpu_data_rd};
      ctl_s   <= zpu_ctl;
      cmd_q   <= ctl_s[2:1];
    end
  end

  assign wr_rise     = wr_sync[1] & ~wr_sync[2];
  assign rd_fall     = ~rd_sync[1] & rd_sync[2];
  assign cmd_rd_rise = ctl_s[1] & ~cmd_q[0];
  assign cmd_wr_rise = ctl_s[2] & ~cmd_q[1];
  assign lba_sel     = ctl_s[0];
  assign drv         = ctl_s[5:3];

  // Sector buffer, pointer and LBA
  logic [7:0]        mem [DEPTH];
  logic [BLK_AW-1:0] ptr;
  logic [7:0]        rd_byte, buff_din;
  logic [31:0]       lba;

  // Both ports share one process; on an address collision hps_io wins.
  always_ff @(posedge clk_sys) begin
    if (wr_rise && !lba_sel) mem[ptr] <= zpu_wdata[7:0];
    if (sd.sd_buff_wr) mem[sd.sd_buff_addr] <= sd.sd_buff_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      rd_byte  <= '0;
      buff_din <= '0;
      ptr      <= '0;
      lba      <= '0;
    end else begin
      rd_byte  <= mem[ptr];
      buff_din <= mem[sd.sd_buff_addr];
      if (zpu_io_wr)
        ptr <= '0;
      else if ((wr_rise && !lba_sel) || rd_fall)
        ptr <= ptr + 1'b1;
      if (wr_rise && lba_sel) lba <= zpu_wdata;
    end
  end

  // Block request FSM
  state_t          state, state_nxt;
  logic [NDRV-1:0] req_rd, req_wr, rd_nxt, wr_nxt, drv_onehot;
  logic            io_done, err, done_nxt, err_nxt, ack_q, ack_fall, drv_ok, timeout_hit;
  logic [23:0]     tcnt, tcnt_nxt;

  assign drv_onehot  = NDRV'(1) << drv;
  assign drv_ok      = {29'd0, drv} < 32'(NDRV);
  assign ack_fall    = ack_q & ~sd.sd_ack;
  assign timeout_hit = (TIMEOUT != 24'd0) && (tcnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      state   <= ST_IDLE;
      req_rd  <= '0;
      req_wr  <= '0;
      io_done <= 1'b0;
      err     <= 1'b0;
      tcnt    <= '0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_rd  <= rd_nxt;
      req_wr  <= wr_nxt;
      io_done <= done_nxt;
      err     <= err_nxt;
      tcnt    <= tcnt_nxt;
      ack_q   <= sd.sd_ack;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = req_rd;
    wr_nxt    = req_wr;
    done_nxt  = io_done;
    err_nxt   = err;
    tcnt_nxt  = tcnt + 24'd1;
    case (state)
      ST_IDLE: begin
        tcnt_nxt = '0;
        if (cmd_rd_rise || cmd_wr_rise) begin
          if (drv_ok) begin
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
            // read wins when both command bits rise together
            if (cmd_rd_rise) rd_nxt = drv_onehot;
            else             wr_nxt = drv_onehot;
            state_nxt = ST_REQ;
          end else begin
            err_nxt  = 1'b1;
            done_nxt = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (sd.sd_ack) begin
          rd_nxt    = '0;
          wr_nxt    = '0;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // a completed transfer in the same cycle beats the timeout
    if (state != ST_IDLE && timeout_hit && !(state == ST_XFER && ack_fall)) begin
      rd_nxt    = '0;
      wr_nxt    = '0;
      err_nxt   = 1'b1;
      done_nxt  = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  // Mount queue: every pulse sets a pending bit; reports drain lowest slot first
  logic [NDRV-1:0] pend, clr_mask;
  logic [7:0]      ro_q;
  logic [31:0]     size_q [8];
  logic [2:0]      fileno, sel;
  logic [1:0]      ftype;
  logic            readonly, mnt_toggle, report;
  logic [15:0]     hold;

  always_comb begin
    sel = '0;
    for (int i = NDRV - 1; i >= 0; i--)
      if (pend[i]) sel = 3'(i);
  end

  assign report   = (pend != '0) && (hold == 16'd0);
  assign clr_mask = report ? (NDRV'(1) << sel) : '0;

  always_ff @(posedge clk_sys) begin
    if (areset) begin
      pend       <= '0;
      ro_q       <= '0;
      fileno     <= '0;
      ftype      <= '0;
      readonly   <= 1'b0;
      mnt_toggle <= 1'b0;
      hold       <= '0;
      for (int i = 0; i < 8; i++) size_q[i] <= '0;
    end else begin
      // a new pulse on the slot being reported keeps it pending
      pend <= (pend & ~clr_mask) | sd.img_mounted;
      for (int i = 0; i < NDRV; i++) begin
        if (sd.img_mounted[i]) begin
          ro_q[i]   <= sd.img_readonly | RO_MASK[i];
          size_q[i] <= sd.img_size[31:0];
        end
      end
      if (sd.img_mounted != '0) ftype <= sd.ioctl_index[7:6];
      if (report) begin
        fileno     <= sel;
        readonly   <= ro_q[sel];
        mnt_toggle <= ~mnt_toggle;
        hold       <= MNT_HOLD;
      end else if (hold != 16'd0) begin
        hold <= hold - 16'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sd.img_size[63:32], sd.ioctl_index[5:0]};

  assign zpu_status     = {readonly, ftype, fileno, mnt_toggle, io_done};
  assign zpu_err        = err;
  assign zpu_rdata      = lba_sel ? size_q[fileno] : {24'd0, rd_byte};
  assign sd.sd_lba      = lba;
  assign sd.sd_rd       = req_rd;
  assign sd.sd_wr       = req_wr;
  assign sd.sd_buff_din = buff_din;

endmodule

// File: tb/tb_sio_sd_bridge.sv
// tb/tb_sio_sd_bridge.sv - directed self-checking bench for sio_sd_bridge
module tb_sio_sd_bridge;

  logic        clk_sys = 1'b0;
  logic        areset;
  logic [5:0]  zpu_ctl;
  logic [31:0] zpu_wdata;
  logic        zpu_data_wr, zpu_data_rd, zpu_io_wr;
  logic [7:0]  zpu_status;
  logic        zpu_err;
  logic [31:0] zpu_rdata;

  int vectors = 0;
  int miscompares = 0;

  sio_sd_bridge_if #(.NDRV(3), .BLK_AW(9)) sd_if ();

  sio_sd_bridge #(
    .NDRV(3), .BLK_AW(9), .TIMEOUT(24'd100), .MNT_HOLD(16'd16), .RO_MASK(3'b100)
  ) dut (
    .clk_sys(clk_sys), .areset(areset),
    .zpu_ctl(zpu_ctl), .zpu_wdata(zpu_wdata),
    .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd), .zpu_io_wr(zpu_io_wr),
    .zpu_status(zpu_status), .zpu_err(zpu_err), .zpu_rdata(zpu_rdata),
    .sd(sd_if)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic zpu_write(input logic [5:0] ctl, input logic [31:0] d);
    zpu_ctl = ctl; zpu_wdata = d; tick(3);
    zpu_data_wr = 1'b1; tick(4);
    zpu_data_wr = 1'b0; tick(3);
  endtask

  task automatic pulse_io_wr();
    zpu_io_wr = 1'b1; tick(1);
    zpu_io_wr = 1'b0; tick(1);
  endtask

  task automatic pulse_data_rd();
    zpu_data_rd = 1'b1; tick(4);
    zpu_data_rd = 1'b0; tick(5);
  endtask

  task automatic test_reset();
    areset = 1'b1; tick(3); areset = 1'b0; tick(1);
    vectors++; if (zpu_status !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h expected 00", zpu_status); end
    vectors++; if (zpu_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", zpu_err); end
    vectors++; if (zpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", zpu_rdata); end
    vectors++; if ({sd_if.sd_rd, sd_if.sd_wr} !== 6'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 000000", {sd_if.sd_rd, sd_if.sd_wr}); end
    vectors++; if (sd_if.sd_lba !== 32'h0) begin miscompares++; $display("FAIL reset_lba: got %h expected 0", sd_if.sd_lba); end
  endtask

  task automatic test_lba_read();
    zpu_write(6'b000_001, 32'h0000_1234);
    vectors++; if (sd_if.sd_lba !== 32'h0000_1234) begin miscompares++; $display("FAIL lba_write: got %h expected 00001234", sd_if.sd_lba); end
    zpu_ctl = 6'b001_010;
    for (int k = 0; k < 10 && sd_if.sd_rd == 3'b000; k++) tick(1);
    vectors++; if (sd_if.sd_rd !== 3'b010) begin miscompares++; $display("FAIL rd_request: got %b expected 010", sd_if.sd_rd); end
    vectors++; if (zpu_status[0] !== 1'b0) begin miscompares++; $display("FAIL rd_io_done_low: got %b expected 0", zpu_status[0]); end
    zpu_ctl = 6'b000_000;
    tick(5);
    vectors++; if (sd_if.sd_rd !== 3'b010 || sd_if.sd_wr !== 3'b000) begin miscompares++; $display("FAIL rd_hold: got rd=%b wr=%b expected 010/000", sd_if.sd_rd, sd_if.sd_wr); end
    sd_if.sd_ack = 1'b1; tick(1);
    vectors++; if (sd_if.sd_rd !== 3'b000) begin miscompares++; $display("FAIL rd_clear_on_ack: got %b expected 000", sd_if.sd_rd); end
    tick(3);
    sd_if.sd_ack = 1'b0;
    vectors++; if (zpu_status[0] !== 1'b0) begin miscompares++; $display("FAIL io_done_before_fall: got %b expected 0", zpu_status[0]); end
    tick(1);
    vectors++; if (zpu_status[0] !== 1'b1 || zpu_err !== 1'b0) begin miscompares++; $display("FAIL io_done_after_fall: got done=%b err=%b expected 1/0", zpu_status[0], zpu_err); end
  endtask

  task automatic test_bad_drive();
    logic saw_req;
    saw_req = 1'b0;
    zpu_ctl = 6'b101_010;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (sd_if.sd_rd != 3'b000 || sd_if.sd_wr != 3'b000) saw_req = 1'b1;
    end
    zpu_ctl = 6'b000_000;
    vectors++; if (saw_req !== 1'b0) begin miscompares++; $display("FAIL bad_drive_no_req: got %b expected 0", saw_req); end
    vectors++; if (zpu_err !== 1'b1 || zpu_status[0] !== 1'b1) begin miscompares++; $display("FAIL bad_drive_err: got err=%b done=%b expected 1/1", zpu_err, zpu_status[0]); end
    tick(2);
  endtask

  task automatic test_timeout();
    int n;
    zpu_ctl = 6'b000_100;
    for (int k = 0; k < 10 && sd_if.sd_wr == 3'b000; k++) tick(1);
    vectors++; if (sd_if.sd_wr !== 3'b001) begin miscompares++; $display("FAIL wr_request: got %b expected 001", sd_if.sd_wr); end
    vectors++; if (zpu_err !== 1'b0 || zpu_status[0] !== 1'b0) begin miscompares++; $display("FAIL wr_start_flags: got err=%b done=%b expected 0/0", zpu_err, zpu_status[0]); end
    zpu_ctl = 6'b000_000;
    tick(90);
    n = 90;
    vectors++; if (sd_if.sd_wr !== 3'b001) begin miscompares++; $display("FAIL wr_before_timeout: got %b expected 001", sd_if.sd_wr); end
    for (int k = 0; k < 20 && sd_if.sd_wr != 3'b000; k++) begin tick(1); n++; end
    vectors++; if (n !== 100) begin miscompares++; $display("FAIL timeout_cycle: got %0d expected 100", n); end
    vectors++; if (sd_if.sd_wr !== 3'b000 || zpu_err !== 1'b1 || zpu_status[0] !== 1'b1) begin miscompares++; $display("FAIL timeout_flags: got wr=%b err=%b done=%b expected 000/1/1", sd_if.sd_wr, zpu_err, zpu_status[0]); end
  endtask

  task automatic test_buffer();
    zpu_ctl = 6'b000_000; tick(2);
    pulse_io_wr();
    zpu_write(6'b000_000, 32'h0000_00A5);
    zpu_write(6'b000_000, 32'h0000_005A);
    sd_if.sd_buff_addr = 9'd0; tick(1);
    vectors++; if (sd_if.sd_buff_din !== 8'hA5) begin miscompares++; $display("FAIL buf_addr0: got %h expected a5", sd_if.sd_buff_din); end
    sd_if.sd_buff_addr = 9'd1; tick(1);
    vectors++; if (sd_if.sd_buff_din !== 8'h5A) begin miscompares++; $display("FAIL buf_addr1: got %h expected 5a", sd_if.sd_buff_din); end
    sd_if.sd_buff_addr = 9'd2; sd_if.sd_buff_dout = 8'h3C; sd_if.sd_buff_wr = 1'b1; tick(1);
    sd_if.sd_buff_wr = 1'b0;
    pulse_io_wr(); tick(1);
    vectors++; if (zpu_rdata !== 32'h0000_00A5) begin miscompares++; $display("FAIL zpu_read_ptr0: got %h expected 000000a5", zpu_rdata); end
    pulse_data_rd();
    vectors++; if (zpu_rdata !== 32'h0000_005A) begin miscompares++; $display("FAIL zpu_read_ptr1: got %h expected 0000005a", zpu_rdata); end
    pulse_data_rd();
    vectors++; if (zpu_rdata !== 32'h0000_003C) begin miscompares++; $display("FAIL zpu_read_hps_byte: got %h expected 0000003c", zpu_rdata); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    pulse_io_wr();
    for (int i = 0; i < 512; i++) begin
      b = 8'(i) ^ 8'h5A;
      zpu_write(6'b000_000, {24'd0, b});
    end
    zpu_write(6'b000_000, 32'h0000_00C3);
    sd_if.sd_buff_addr = 9'd0; tick(1);
    vectors++; if (sd_if.sd_buff_din !== 8'hC3) begin miscompares++; $display("FAIL wrap_addr0: got %h expected c3", sd_if.sd_buff_din); end
    sd_if.sd_buff_addr = 9'd1; tick(1);
    vectors++; if (sd_if.sd_buff_din !== 8'h5B) begin miscompares++; $display("FAIL wrap_addr1: got %h expected 5b", sd_if.sd_buff_din); end
    sd_if.sd_buff_addr = 9'd511; tick(1);
    vectors++; if (sd_if.sd_buff_din !== 8'hA5) begin miscompares++; $display("FAIL wrap_addr511: got %h expected a5", sd_if.sd_buff_din); end
    vectors++; if (zpu_rdata !== 32'h0000_005B) begin miscompares++; $display("FAIL wrap_ptr1: got %h expected 0000005b", zpu_rdata); end
  endtask

  task automatic test_mount();
    logic t0;
    int gap;
    t0 = zpu_status[1];
    sd_if.img_readonly = 1'b0;
    sd_if.img_size = 64'h0000_0001_0000_0ABC;
    sd_if.ioctl_index = 8'hC0;
    sd_if.img_mounted = 3'b101; tick(1);
    sd_if.img_mounted = 3'b000;
    for (int k = 0; k < 10 && zpu_status[1] == t0; k++) tick(1);
    vectors++; if (zpu_status[1] !== ~t0) begin miscompares++; $display("FAIL mount1_toggle: got %b expected %b", zpu_status[1], ~t0); end
    vectors++; if (zpu_status[7:2] !== 6'b0_11_000) begin miscompares++; $display("FAIL mount1_info: got %b expected 011000", zpu_status[7:2]); end
    zpu_ctl = 6'b000_001; tick(2);
    vectors++; if (zpu_rdata !== 32'h0000_0ABC) begin miscompares++; $display("FAIL mount1_size: got %h expected 00000abc", zpu_rdata); end
    tick(6);
    gap = 8;
    vectors++; if (zpu_status[1] !== ~t0) begin miscompares++; $display("FAIL mount_hold: got %b expected %b", zpu_status[1], ~t0); end
    for (int k = 0; k < 30 && zpu_status[1] != t0; k++) begin tick(1); gap++; end
    vectors++; if (gap < 16 || gap > 18) begin miscompares++; $display("FAIL mount_gap: got %0d expected 16..18", gap); end
    vectors++; if (zpu_status[7:1] !== {1'b1, 2'b11, 3'd2, t0}) begin miscompares++; $display("FAIL mount2_info: got %b expected %b", zpu_status[7:1], {1'b1, 2'b11, 3'd2, t0}); end
    tick(40);
    vectors++; if (zpu_status[1] !== t0) begin miscompares++; $display("FAIL mount_no_third: got %b expected %b", zpu_status[1], t0); end
    zpu_ctl = 6'b000_000; tick(2);
  endtask

  task automatic test_areset_xfer();
    zpu_ctl = 6'b010_110;
    for (int k = 0; k < 10 && sd_if.sd_rd == 3'b000; k++) tick(1);
    vectors++; if (sd_if.sd_rd !== 3'b100 || sd_if.sd_wr !== 3'b000) begin miscompares++; $display("FAIL both_rise_rd_wins: got rd=%b wr=%b expected 100/000", sd_if.sd_rd, sd_if.sd_wr); end
    zpu_ctl = 6'b000_000;
    sd_if.sd_ack = 1'b1; tick(2);
    sd_if.img_mounted = 3'b011; tick(1);
    sd_if.img_mounted = 3'b000; tick(4);
    areset = 1'b1; sd_if.sd_ack = 1'b0; tick(1);
    vectors++; if (zpu_status !== 8'h00 || zpu_err !== 1'b0 || zpu_rdata !== 32'h0) begin miscompares++; $display("FAIL areset_zpu: got st=%h err=%b rdata=%h expected 00/0/0", zpu_status, zpu_err, zpu_rdata); end
    vectors++; if ({sd_if.sd_rd, sd_if.sd_wr} !== 6'b0 || sd_if.sd_lba !== 32'h0 || sd_if.sd_buff_din !== 8'h0) begin miscompares++; $display("FAIL areset_sd: got req=%b lba=%h din=%h expected 0/0/0", {sd_if.sd_rd, sd_if.sd_wr}, sd_if.sd_lba, sd_if.sd_buff_din); end
    areset = 1'b0; tick(40);
    vectors++; if (zpu_status[1] !== 1'b0) begin miscompares++; $display("FAIL areset_pend_dropped: got %b expected 0", zpu_status[1]); end
  endtask

  initial begin
    areset = 1'b1;
    zpu_ctl = '0; zpu_wdata = '0;
    zpu_data_wr = 1'b0; zpu_data_rd = 1'b0; zpu_io_wr = 1'b0;
    sd_if.sd_ack = 1'b0; sd_if.sd_buff_addr = '0; sd_if.sd_buff_dout = '0; sd_if.sd_buff_wr = 1'b0;
    sd_if.img_mounted = '0; sd_if.img_readonly = 1'b0; sd_if.img_size = '0; sd_if.ioctl_index = '0;
    test_reset();
    test_lba_read();
    test_bad_drive();
    test_timeout();
    test_buffer();
    test_wrap();
    test_mount();
    test_areset_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
